// File: rtl/fir_decim_out.sv
// fir_decim_out: output stage for the 65-tap FIR.
//
// Takes the raw signed FIR accumulator and keeps one sample in every DECIM valid
// inputs. The kept sample is rescaled by SHIFT with round-half-up, clamped to a
// signed OUT_WIDTH result, and queued in a first-word-fall-through FIFO with a
// valid/ready handshake toward the consumer.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset; discards in-flight and buffered data
//   din         signed FIR output sample (IN_WIDTH)
//   din_valid   din carries a new sample this cycle
//   dout        signed output sample, the FIFO head (zero while empty)
//   dout_valid  FIFO non-empty
//   dout_ready  consumer takes dout this cycle
//   fifo_level  FIFO occupancy, 0..FIFO_DEPTH
//   overflow    sticky: a kept sample was dropped because the FIFO was full
//   sat_cnt     number of kept samples that clamped, holds at 255
//
// Latency: a kept din sampled at edge t is in stage 1 after t, stage 2 after t+1,
// and in the FIFO (visible on dout) after t+2.
module fir_decim_out #(
  parameter int unsigned IN_WIDTH   = 23,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned SHIFT      = 12,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IN_WIDTH-1:0]           din,
  input  logic                          din_valid,
  output logic [OUT_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    sat_cnt
);

  localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = AddrW + 1;
  // One guard bit so the rounding bias can never overflow the sum.
  localparam int unsigned RW     = IN_WIDTH + 1;

  localparam logic signed [RW-1:0] RoundBias = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] QMax      = (RW'(1) << (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] QMin      = ~QMax;

  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------------------
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              keep;

  always_comb begin
    phase_d = phase_q;
    if (din_valid) begin
      phase_d = (phase_q == PhaseW'(DECIM - 1)) ? '0 : phase_q + PhaseW'(1);
    end
  end

  assign keep = din_valid && (phase_q == '0);

  // ---------------------------------------------------------------------------
  // Stage 1: sign extend and add half an output LSB
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0] r1_q, r1_d;
  logic                 v1_q;

  assign r1_d = signed'({din[IN_WIDTH-1], din}) + RoundBias;

  // ---------------------------------------------------------------------------
  // Stage 2: arithmetic shift, then clamp to the output range
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0]  q;
  logic [OUT_WIDTH-1:0]  s2_q, s2_d;
  logic                  sat2_q, sat2_d;
  logic                  v2_q;

  assign q = r1_q >>> SHIFT;

  always_comb begin
    s2_d   = q[OUT_WIDTH-1:0];
    sat2_d = 1'b0;
    if (q > QMax) begin
      s2_d   = OutMax;
      sat2_d = 1'b1;
    end else if (q < QMin) begin
      s2_d   = OutMin;
      sat2_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation counter
  // ---------------------------------------------------------------------------
  logic [7:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (v2_q && sat2_q && (sat_cnt_q != 8'hFF)) begin
      sat_cnt_d = sat_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]    level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 full, empty;
  logic                 pop, push_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LevelW'(FIFO_DEPTH));
  // Pop only when there is something to pop, so a push into an empty FIFO
  // never bypasses to dout in the same cycle.
  assign pop   = !empty && dout_ready;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign push_ok = v2_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
    if (v2_q && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // Storage is not reset; dout is gated by level so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= s2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      r1_q       <= '0;
      v1_q       <= 1'b0;
      s2_q       <= '0;
      sat2_q     <= 1'b0;
      v2_q       <= 1'b0;
      sat_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      v1_q    <= keep;
      if (keep) begin
        r1_q <= r1_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q   <= s2_d;
        sat2_q <= sat2_d;
      end
      sat_cnt_q  <= sat_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign sat_cnt    = sat_cnt_q;

endmodule
